// File: rtl/decode_pkg.sv
// Shared decode constants for the register select/encode path: instruction
// word width, default register-field positions and the C immediate width.
package decode_pkg;

  localparam int IR_W       = 32;

  localparam int DEF_RA_LSB = 23;
  localparam int DEF_RB_LSB = 19;
  localparam int DEF_RC_LSB = 15;
  localparam int DEF_C_W    = 19;

  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 27;

endpackage : decode_pkg

// File: rtl/onehot_decoder.sv
// Binary index to one-hot decoder with an enable; all outputs low when
// the enable is deasserted.
module onehot_decoder #(
  parameter int IDX_W = 4,
  parameter int OUT_W = 1 << IDX_W
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] onehot
);

  // Raise exactly the bit addressed by idx when enabled.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (en && (idx == IDX_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule : onehot_decoder

// File: rtl/sel_encode_regfile.sv
// Register select/encode path with the general register file. Latches the
// instruction word, picks a register number from the Ra/Rb/Rc field chosen
// by Gra/Grb/Grc, drives one-hot write/read strobes and serves the bus.
// R0 reads as zero for base-address reads (BA_out) but stores normally.
module sel_encode_regfile
  import decode_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int RA_LSB   = DEF_RA_LSB,
  parameter int RB_LSB   = DEF_RB_LSB,
  parameter int RC_LSB   = DEF_RC_LSB,
  parameter int C_W      = DEF_C_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ir_load,
  input  logic [IR_W-1:0]     ir_in,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                r_in_enable,
  input  logic                r_out_enable,
  input  logic                BA_out,
  input  logic [DATA_W-1:0]   bus_in,
  output logic [DATA_W-1:0]   bus_out,
  output logic [IDX_W-1:0]    rnum,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic [DATA_W-1:0]   c_sign_ext,
  output logic                sel_err
);

  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [1:0]        sel_cnt;
  logic              single_sel;
  logic              multi_sel;
  logic              unused_ir;

  assign sel_cnt    = 2'(Gra) + 2'(Grb) + 2'(Grc);
  assign single_sel = (sel_cnt == 2'd1);
  assign multi_sel  = (sel_cnt > 2'd1);

  // Opcode and spare IR bits are consumed elsewhere in the datapath.
  assign unused_ir  = ^ir;

  // Instruction register: captured from the bus on ir_load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else if (ir_load) begin
      ir <= ir_in;
    end
  end

  // Register number from the single selected field; conflicting or absent
  // selects give R0 with the strobes suppressed below.
  always_comb begin
    rnum = '0;
    if (single_sel) begin
      if (Gra) begin
        rnum = ir[RA_LSB +: IDX_W];
      end else if (Grb) begin
        rnum = ir[RB_LSB +: IDX_W];
      end else begin
        rnum = ir[RC_LSB +: IDX_W];
      end
    end
  end

  onehot_decoder #(
    .IDX_W (IDX_W),
    .OUT_W (NUM_REGS)
  ) u_rin_dec (
    .en     (r_in_enable & single_sel),
    .idx    (rnum),
    .onehot (r_in)
  );

  onehot_decoder #(
    .IDX_W (IDX_W),
    .OUT_W (NUM_REGS)
  ) u_rout_dec (
    .en     ((r_out_enable | BA_out) & single_sel),
    .idx    (rnum),
    .onehot (r_out)
  );

  // Sticky select-conflict flag, cleared by the next instruction load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (ir_load) begin
      sel_err <= 1'b0;
    end else if (multi_sel) begin
      sel_err <= 1'b1;
    end
  end

  // Register storage: write the strobed register from bus_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (|r_in) begin
      regs[rnum] <= bus_in;
    end
  end

  // Zero-latency read; a BA read of R0 yields the zero base address.
  always_comb begin
    bus_out = '0;
    if ((|r_out) && !(BA_out && (rnum == '0))) begin
      bus_out = regs[rnum];
    end
  end

  assign c_sign_ext = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

endmodule : sel_encode_regfile

// File: doc/sel_encode_regfile.md
Name: sel_encode_regfile

Overview:
- Parametrised successor to the fixed 16-register select/encode path.
- Latches the instruction word and derives the register number from the Ra/Rb/Rc fields under Gra/Grb/Grc.
- Drives one-hot r_in/r_out vectors and owns the register storage with BA (base-address) zero semantics on R0.
- Sits between the control unit and the datapath bus; also produces the sign-extended C constant.

Parameters:
- DATA_W, 32, register and bus width
- NUM_REGS, 16, number of general registers (power of two, 2..64)
- IDX_W, $clog2(NUM_REGS), register-field width
- RA_LSB, 23, LSB of Ra field in IR
- RB_LSB, 19, LSB of Rb field in IR
- RC_LSB, 15, LSB of Rc field in IR
- C_W, 19, width of the C immediate field (IR[C_W-1:0])

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ir_load  in  1  capture ir_in into internal IR
- ir_in  in  32  instruction word from bus
- Gra  in  1  select Ra field
- Grb  in  1  select Rb field
- Grc  in  1  select Rc field
- r_in_enable  in  1  write selected register from bus_in
- r_out_enable  in  1  drive selected register onto bus_out
- BA_out  in  1  base-address read; R0 reads as zero
- bus_in  in  DATA_W  write data
- bus_out  out  DATA_W  read data, zero when not reading
- rnum  out  IDX_W  currently selected register number
- r_in  out  NUM_REGS  one-hot write strobe vector
- r_out  out  NUM_REGS  one-hot read select vector
- c_sign_ext  out  DATA_W  IR[C_W-1:0] sign-extended to DATA_W
- sel_err  out  1  sticky: more than one of Gra/Grb/Grc was seen together

Behaviour:
- Reset (rst_n low, asynchronous):
  - IR, all registers and sel_err go to 0.
  - Hence rnum=0, r_in=0, r_out=0, bus_out=0, c_sign_ext=0.
  - Reset asserted mid-write: the write is lost and the register reads 0.
- IR: on rising clk with ir_load=1, IR <= ir_in. Field outputs update the cycle after load.
- rnum (combinational from IR):
  - Gra alone -> IR[RA_LSB+:IDX_W]; Grb alone -> Rb field; Grc alone -> Rc field.
  - None asserted -> 0.
  - More than one asserted -> rnum=0, r_in=r_out=0 (no select), and sel_err sets on the next clk edge.
- sel_err: clears on ir_load (ir_load takes priority over a simultaneous set).
- Fields wider than IDX_W: upper IR bits are ignored (index truncates, no wrap error).
- r_in = onehot(rnum) when r_in_enable and a single Gr is asserted, else 0.
- r_out = onehot(rnum) when (r_out_enable | BA_out) and a single Gr is asserted, else 0.
- Write: on rising clk, reg[rnum] <= bus_in when r_in is nonzero. R0 is writable and stores normally.
- Read (combinational, zero latency):
  - bus_out = reg[rnum] when r_out is nonzero.
  - BA_out with rnum==0 -> bus_out=0 regardless of stored R0.
  - r_out_enable with rnum==0 -> stored R0.
  - Both r_out_enable and BA_out asserted -> BA rule wins.
- Read and write of the same register in the same cycle: bus_out shows the old value; the new value is visible the next cycle (no bypass).
- r_in_enable and r_out_enable together are legal.
- c_sign_ext = {{(DATA_W-C_W){IR[C_W-1]}}, IR[C_W-1:0]}.

Decomposition:
- Shared package (decode_pkg):
  - Default field LSBs (RA_LSB, RB_LSB, RC_LSB), C_W, opcode field position [31:27].
  - Localparam for the IR width (32).
- One sub-module: onehot_decoder (parametrised N-to-2^N with enable), instantiated twice for r_in and r_out.
- Register array and IR stay in the top module.

Test Plan:
- Reset check: drive rst_n=0 mid-write of R5 -> bus_out=0; all regs read 0; sel_err=0; r_in=r_out=0.
- Field select: load IR with Ra=5, Rb=6, Rc=7.
  - Gra+r_in_enable -> r_in=16'h0020, r_out=0.
  - Grb+r_out_enable -> r_out=16'h0040.
  - Grc+BA_out -> r_out=16'h0080.
- Write/read: write 32'hDEADBEEF to R5 via Gra.
  - Read via Gra+r_out_enable -> bus_out=32'hDEADBEEF.
  - Same-cycle read/write of R5 with 32'h1 -> bus_out stays DEADBEEF that cycle, 1 the next.
- BA rule: write 32'h1234 to R0 (Ra=0).
  - Gra+BA_out -> bus_out=0.
  - Gra+r_out_enable -> bus_out=32'h1234.
- Select error: assert Gra and Grb together with r_in_enable.
  - Expect r_in=0 and no register changes; sel_err=1 next cycle.
  - ir_load clears sel_err.
- Sign extension and NUM_REGS=8:
  - IR[18:0]=19'h40000 -> c_sign_ext=32'hFFFC0000.
  - IR[18:0]=19'h3FFFF -> c_sign_ext=32'h0003FFFF.
  - NUM_REGS=8 with Ra field=4'b1101 -> rnum=5, r_in=8'h20.
